// File: rtl/fifo_axi_manager_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_axi_manager_pkg : FSM states, AXI response codes, command field offsets
// Revision: 1.0
// ---------------------------------------------------------------------------
package fifo_axi_manager_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Command word layout is {is_read, addr, wdata}, wdata at bit 0.
  localparam int CMD_DATA_LSB = 0;

  function automatic int cmd_addr_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int cmd_is_read_bit(input int addr_width, input int data_width);
    return addr_width + data_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_axi_manager_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_axi_manager_if : AXI4-Lite bus bundle with manager/subordinate modports
// Revision: 1.0
// ---------------------------------------------------------------------------
interface fifo_axi_manager_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/fifo_axi_manager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_axi_manager : turns FWFT command FIFO entries into single AXI4-Lite accesses
// Revision: 1.0
// ---------------------------------------------------------------------------
module fifo_axi_manager
  import fifo_axi_manager_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int ENABLE_WRITE   = 1,
  parameter int ENABLE_READ    = 1
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [AXI_ADDR_WIDTH+AXI_DATA_WIDTH:0] cmd_rd_data,
  output logic                                   cmd_rd_en,
  input  logic                                   cmd_empty,
  output logic [AXI_DATA_WIDTH+1:0]              resp_wr_data,
  output logic                                   resp_wr_en,
  input  logic                                   resp_full,
  fifo_axi_manager_if.master                     m_axi,
  output logic                                   busy,
  output logic                                   wr_error,
  output logic                                   rd_error,
  output logic                                   cmd_error
);

  localparam int IS_READ_BIT = cmd_is_read_bit(AXI_ADDR_WIDTH, AXI_DATA_WIDTH);
  localparam int ADDR_LSB    = cmd_addr_lsb(AXI_DATA_WIDTH);

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic                      r_awvalid;
  logic                      r_wvalid;
  logic                      r_arvalid;
  logic                      r_wr_error;
  logic                      r_rd_error;
  logic                      r_cmd_error;

  logic w_cmd_is_read;
  logic w_pop;
  logic w_aw_ok;
  logic w_w_ok;
  logic w_r_take;

  // Reads only pop when the response FIFO can take the result later.
  assign w_cmd_is_read = cmd_rd_data[IS_READ_BIT];
  assign w_pop    = (state == S_IDLE) && !areset && !cmd_empty && !(w_cmd_is_read && resp_full);
  assign w_aw_ok  = !r_awvalid || m_axi.awready;
  assign w_w_ok   = !r_wvalid  || m_axi.wready;
  assign w_r_take = (state == S_RD_RESP) && m_axi.rvalid;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_wr_error  <= 1'b0;
      r_rd_error  <= 1'b0;
      r_cmd_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (w_pop) begin
            r_addr  <= cmd_rd_data[ADDR_LSB +: AXI_ADDR_WIDTH];
            r_wdata <= cmd_rd_data[CMD_DATA_LSB +: AXI_DATA_WIDTH];
            if (w_cmd_is_read) begin
              if (ENABLE_READ != 0) begin
                r_arvalid <= 1'b1;
                state     <= S_RD_ADDR;
              end else begin
                r_cmd_error <= 1'b1;
              end
            end else begin
              if (ENABLE_WRITE != 0) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                state     <= S_WR;
              end else begin
                r_cmd_error <= 1'b1;
              end
            end
          end
        end
        S_WR: begin
          // Address and data channels complete independently, in either order.
          if (m_axi.awready) r_awvalid <= 1'b0;
          if (m_axi.wready)  r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) state <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (m_axi.bvalid) begin
            if (m_axi.bresp != RESP_OKAY) r_wr_error <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (m_axi.arready) begin
            r_arvalid <= 1'b0;
            state     <= S_RD_RESP;
          end
        end
        S_RD_RESP: begin
          if (m_axi.rvalid) begin
            if (m_axi.rresp != RESP_OKAY) r_rd_error <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_rd_en     = w_pop;
  assign resp_wr_en    = w_r_take;
  assign resp_wr_data  = w_r_take ? {m_axi.rresp, m_axi.rdata} : '0;

  assign m_axi.awaddr  = r_addr;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = (state == S_WR_RESP);
  assign m_axi.araddr  = r_addr;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = (state == S_RD_RESP);

  assign busy      = (state != S_IDLE);
  assign wr_error  = r_wr_error;
  assign rd_error  = r_rd_error;
  assign cmd_error = r_cmd_error;

endmodule
`default_nettype wire

// File: tb/tb_fifo_axi_manager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_axi_manager : directed and randomized bench for fifo_axi_manager
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fifo_axi_manager;
  import fifo_axi_manager_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 1 + AW + DW;
  localparam int N_RAND = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic [CW-1:0] cmd_rd_data, cmd_rd_data_nw;
  logic          cmd_rd_en, cmd_rd_en_nw;
  logic          cmd_empty, cmd_empty_nw;
  logic [DW+1:0] resp_wr_data, resp_wr_data_nw;
  logic          resp_wr_en, resp_wr_en_nw;
  logic          resp_full, resp_full_nw;
  logic          busy, wr_error, rd_error, cmd_error;
  logic          busy_nw, wr_error_nw, rd_error_nw, cmd_error_nw;

  fifo_axi_manager_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  fifo_axi_manager_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_nw ();

  fifo_axi_manager #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .ENABLE_WRITE(1), .ENABLE_READ(1)) dut (
    .aclk(clk), .areset(areset),
    .cmd_rd_data(cmd_rd_data), .cmd_rd_en(cmd_rd_en), .cmd_empty(cmd_empty),
    .resp_wr_data(resp_wr_data), .resp_wr_en(resp_wr_en), .resp_full(resp_full),
    .m_axi(bus.master),
    .busy(busy), .wr_error(wr_error), .rd_error(rd_error), .cmd_error(cmd_error)
  );

  fifo_axi_manager #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .ENABLE_WRITE(0), .ENABLE_READ(1)) dut_nw (
    .aclk(clk), .areset(areset),
    .cmd_rd_data(cmd_rd_data_nw), .cmd_rd_en(cmd_rd_en_nw), .cmd_empty(cmd_empty_nw),
    .resp_wr_data(resp_wr_data_nw), .resp_wr_en(resp_wr_en_nw), .resp_full(resp_full_nw),
    .m_axi(bus_nw.master),
    .busy(busy_nw), .wr_error(wr_error_nw), .rd_error(rd_error_nw), .cmd_error(cmd_error_nw)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {rd, a, d};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Reference model state: commands in issue order plus subordinate bookkeeping.
  logic [CW-1:0] cmd_q[$];
  logic [CW-1:0] exp_q[$];
  int            n_pushed = 0, n_rd_cmds = 0, n_pushes = 0;
  bit            exp_wr_err = 0, exp_rd_err = 0;
  bit            aw_seen = 0, w_seen = 0, b_arm = 0, r_arm = 0, b_take = 0, r_take = 0;
  int            b_wait = 0, r_wait = 0;
  logic [AW-1:0] seen_awaddr, seen_araddr, held_awaddr, held_araddr;
  logic [DW-1:0] seen_wdata, held_wdata;
  bit            aw_pend = 0, w_pend = 0, ar_pend = 0;

  task automatic rand_cycle();
    logic [CW-1:0] c;
    logic          r_hs;
    @(negedge clk);
    if (b_take) begin bus.bvalid = 1'b0; b_take = 0; end
    if (r_take) begin bus.rvalid = 1'b0; r_take = 0; end
    if (n_pushed < N_RAND && $urandom_range(0, 2) == 0) begin
      c = {1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom)};
      cmd_q.push_back(c);
      exp_q.push_back(c);
      n_pushed++;
      if (c[CW-1]) n_rd_cmds++;
    end
    cmd_empty    = (cmd_q.size() == 0);
    cmd_rd_data  = cmd_empty ? '0 : cmd_q[0];
    resp_full    = ($urandom_range(0, 3) == 0);
    bus.awready  = 1'($urandom_range(0, 1));
    bus.wready   = 1'($urandom_range(0, 1));
    bus.arready  = 1'($urandom_range(0, 1));
    if (b_arm && !bus.bvalid) begin
      if (b_wait == 0) begin bus.bvalid = 1'b1; bus.bresp = 2'($urandom); b_arm = 0; end
      else b_wait--;
    end
    if (r_arm && !bus.rvalid) begin
      if (r_wait == 0) begin
        bus.rvalid = 1'b1; bus.rdata = $urandom; bus.rresp = 2'($urandom); r_arm = 0;
      end else r_wait--;
    end
    #1;
    // A valid waiting for ready must stay high with a stable payload.
    if (aw_pend) check("aw_hold", {bus.awvalid, bus.awaddr}, {1'b1, held_awaddr});
    if (w_pend)  check("w_hold",  {bus.wvalid, bus.wdata},   {1'b1, held_wdata});
    if (ar_pend) check("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, held_araddr});
    aw_pend = bus.awvalid && !bus.awready; held_awaddr = bus.awaddr;
    w_pend  = bus.wvalid  && !bus.wready;  held_wdata  = bus.wdata;
    ar_pend = bus.arvalid && !bus.arready; held_araddr = bus.araddr;
    if (bus.arvalid) check("one_outstanding", {bus.awvalid, bus.wvalid, bus.bready}, 3'b000);
    if (cmd_rd_en) begin
      check("pop_eligible", {cmd_empty, cmd_rd_data[CW-1] & resp_full}, 2'b00);
      if (cmd_q.size() > 0) cmd_q.delete(0);
    end
    if (bus.awvalid && bus.awready) begin aw_seen = 1; seen_awaddr = bus.awaddr; end
    if (bus.wvalid && bus.wready) begin
      w_seen = 1; seen_wdata = bus.wdata;
      check("wstrb", bus.wstrb, 4'hF);
    end
    if (aw_seen && w_seen) begin
      aw_seen = 0; w_seen = 0; b_arm = 1; b_wait = $urandom_range(0, 3);
    end
    if (bus.bvalid && bus.bready) begin
      b_take = 1;
      if (bus.bresp != RESP_OKAY) exp_wr_err = 1;
      c = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("wr_txn", {1'b0, seen_awaddr, seen_wdata}, c);
    end
    if (bus.arvalid && bus.arready) begin
      seen_araddr = bus.araddr; r_arm = 1; r_wait = $urandom_range(0, 3);
    end
    r_hs = bus.rvalid && bus.rready;
    if (resp_wr_en) n_pushes++;
    if (r_hs || resp_wr_en) check("push_iff_r", resp_wr_en, r_hs);
    if (r_hs) begin
      r_take = 1;
      if (bus.rresp != RESP_OKAY) exp_rd_err = 1;
      check("rd_resp", resp_wr_data, {bus.rresp, bus.rdata});
      c = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("rd_txn", {1'b1, seen_araddr}, c[CW-1:DW]);
    end
  endtask

  logic [CW-1:0] bq[$];
  int            pop_cyc[4];
  int            pops;
  bit            drained;

  initial begin
    areset = 1'b1;
    cmd_empty = 1'b0; cmd_rd_data = mk(1'b0, 8'h55, 32'h0); resp_full = 1'b0;
    cmd_empty_nw = 1'b0; cmd_rd_data_nw = mk(1'b0, 8'h66, 32'h0); resp_full_nw = 1'b0;
    bus.awready = 0; bus.wready = 0; bus.bresp = 0; bus.bvalid = 0;
    bus.arready = 0; bus.rdata = 0; bus.rresp = 0; bus.rvalid = 0;
    bus_nw.awready = 0; bus_nw.wready = 0; bus_nw.bresp = 0; bus_nw.bvalid = 0;
    bus_nw.arready = 0; bus_nw.rdata = 0; bus_nw.rresp = 0; bus_nw.rvalid = 0;

    // Reset state, with a command waiting that must not be popped.
    step(); #1;
    check("reset_outputs",
          {busy, wr_error, rd_error, cmd_error, cmd_rd_en, resp_wr_en,
           bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 11'h0);
    check("reset_addr", {bus.awaddr, bus.wdata}, 40'h0);
    check("reset_nw_pop", cmd_rd_en_nw, 1'b0);
    cmd_empty = 1'b1; cmd_empty_nw = 1'b1;
    step(); areset = 1'b0;

    // Single write, zero-wait subordinate.
    step(); cmd_empty = 0; cmd_rd_data = mk(1'b0, 8'h10, 32'hDEADBEEF);
    bus.awready = 1; bus.wready = 1; #1;
    check("wr1_pop_c0", cmd_rd_en, 1'b1);
    step(); cmd_empty = 1; #1;
    check("wr1_valids_c1", {bus.awvalid, bus.wvalid, bus.bready, busy}, 4'b1101);
    check("wr1_payload", {bus.awaddr, bus.wdata, bus.wstrb}, {8'h10, 32'hDEADBEEF, 4'hF});
    step(); bus.bvalid = 1; bus.bresp = RESP_OKAY; #1;
    check("wr1_bready_c2", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
    step(); bus.bvalid = 0; #1;
    check("wr1_idle_c3", {busy, wr_error}, 2'b00);

    // Split write: awready arrives at cycle 4, wready immediate, SLVERR back.
    step(); cmd_empty = 0; cmd_rd_data = mk(1'b0, 8'h20, 32'hCAFEF00D);
    bus.awready = 0; bus.wready = 1; #1;
    check("split_pop", cmd_rd_en, 1'b1);
    step(); cmd_empty = 1; #1;
    check("split_c1", {bus.awvalid, bus.wvalid}, 2'b11);
    for (int c = 2; c <= 4; c++) begin
      step(); if (c == 4) bus.awready = 1; #1;
      check("split_wait", {bus.awvalid, bus.wvalid, bus.bready}, 3'b100);
    end
    step(); bus.awready = 0; bus.bvalid = 1; bus.bresp = RESP_SLVERR; #1;
    check("split_c5", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
    step(); bus.bvalid = 0; #1;
    check("split_wr_error", {busy, wr_error}, 2'b01);

    // Read returning SLVERR.
    step(); cmd_empty = 0; cmd_rd_data = mk(1'b1, 8'h04, 32'h0); bus.arready = 1; #1;
    check("rd_pop", cmd_rd_en, 1'b1);
    step(); cmd_empty = 1; #1;
    check("rd_ar_c1", {bus.arvalid, bus.araddr, bus.rready}, {1'b1, 8'h04, 1'b0});
    step(); bus.rvalid = 1; bus.rdata = 32'h12345678; bus.rresp = RESP_SLVERR; #1;
    check("rd_push_c2", {bus.rready, resp_wr_en, resp_wr_data}, {1'b1, 1'b1, 2'b10, 32'h12345678});
    step(); bus.rvalid = 0; #1;
    check("rd_single_push", {resp_wr_en, busy, rd_error}, 3'b001);

    // Read held back by a full response FIFO.
    step(); cmd_empty = 0; cmd_rd_data = mk(1'b1, 8'h08, 32'h0); resp_full = 1; #1;
    check("bp_no_pop", cmd_rd_en, 1'b0);
    step(); #1;
    check("bp_stall", {cmd_rd_en, bus.arvalid, busy}, 3'b000);
    step(); resp_full = 0; #1;
    check("bp_release_pop", cmd_rd_en, 1'b1);
    step(); cmd_empty = 1; #1;
    check("bp_ar", {bus.arvalid, bus.araddr}, {1'b1, 8'h08});
    step(); bus.rvalid = 1; bus.rdata = 32'hA5A5A5A5; bus.rresp = RESP_OKAY; #1;
    check("bp_push", {resp_wr_en, resp_wr_data}, {1'b1, 2'b00, 32'hA5A5A5A5});
    step(); bus.rvalid = 0; #1;
    check("bp_idle", busy, 1'b0);

    // Write-disabled instance drops the write and flags it.
    step(); cmd_empty_nw = 0; cmd_rd_data_nw = mk(1'b0, 8'h30, 32'h11112222); #1;
    check("nw_pop", cmd_rd_en_nw, 1'b1);
    step(); cmd_empty_nw = 1; #1;
    check("nw_dropped", {bus_nw.awvalid, bus_nw.wvalid, busy_nw, cmd_error_nw}, 4'b0001);
    check("main_cmd_error", cmd_error, 1'b0);

    // Three queued writes against an always-ready subordinate.
    bq.push_back(mk(1'b0, 8'h40, 32'h1)); bq.push_back(mk(1'b0, 8'h44, 32'h2));
    bq.push_back(mk(1'b0, 8'h48, 32'h3));
    bus.awready = 1; bus.wready = 1; pops = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      step();
      cmd_empty = (bq.size() == 0);
      cmd_rd_data = cmd_empty ? '0 : bq[0];
      bus.bvalid = bus.bready; bus.bresp = RESP_OKAY;
      #1;
      if (cmd_rd_en && bq.size() > 0) begin
        if (pops < 4) pop_cyc[pops] = cyc;
        pops++;
        bq.delete(0);
      end
    end
    bus.bvalid = 0; cmd_empty = 1;
    check("b2b_pops", pops, 3);
    check("b2b_gap1", pop_cyc[1] - pop_cyc[0], 3);
    check("b2b_gap2", pop_cyc[2] - pop_cyc[1], 3);

    // Reset while waiting in WR_RESP.
    step(); cmd_empty = 0; cmd_rd_data = mk(1'b0, 8'h50, 32'h77); #1;
    step(); cmd_empty = 1; #1;
    step(); #1;
    check("rst_in_wr_resp", {busy, bus.bready}, 2'b11);
    #1 areset = 1; #1;
    check("rst_async_clear",
          {busy, bus.awvalid, bus.wvalid, bus.bready, wr_error, rd_error}, 6'b0);
    step(); areset = 0;

    // Reset while both write valids are pending.
    bus.awready = 0; bus.wready = 0;
    step(); cmd_empty = 0; cmd_rd_data = mk(1'b0, 8'h60, 32'h88); #1;
    step(); cmd_empty = 1; #1;
    check("rst_in_wr_pre", {bus.awvalid, bus.wvalid}, 2'b11);
    #1 areset = 1; #1;
    check("rst_in_wr_drop", {bus.awvalid, bus.wvalid, busy}, 3'b000);
    step(); areset = 0;

    // Randomized traffic checked against the in-order command model.
    drained = 0;
    for (int i = 0; i < 4000; i++) begin
      rand_cycle();
      if (n_pushed == N_RAND && exp_q.size() == 0 && cmd_q.size() == 0 && !busy) begin
        drained = 1;
        break;
      end
    end
    check("rand_drained", drained, 1'b1);
    check("rand_push_count", n_pushes, n_rd_cmds);
    check("rand_flags", {wr_error, rd_error, cmd_error}, {exp_wr_err, exp_rd_err, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
